// File: rtl/reg_apb2native_if.sv
// reg_apb2native_if
//   APB3 completer that turns each APB transfer into a single native
//   register-interface request (req_vld/ack_vld handshake). One transfer is
//   in flight at a time and every output comes straight from a flop.
//
//   Optional build macro REG_APB2NATIVE_TIMEOUT_EN: when defined, a transfer
//   whose ack_vld has not arrived after TIMEOUT_CYCLES request/wait cycles is
//   completed with pslverr=1 and prdata=0. When undefined, the bridge waits
//   indefinitely for ack_vld and pslverr is tied to 0.
//
//   Ports
//     clk, rst_n        clock, synchronous active-low reset
//     psel, penable,    APB request side (penable is not needed: the
//     pwrite, paddr,      transfer is captured on psel alone)
//     pwdata
//     pready, prdata,   APB response; pready is a one-cycle pulse and
//     pslverr             prdata/pslverr are valid with it
//     req_vld, wr_en,   native request; req_vld is a one-cycle pulse and the
//     rd_en, addr,        qualifiers are only ever high alongside it
//     wr_data
//     ack_vld, rd_data  native completion; rd_data sampled with ack_vld
module reg_apb2native_if #(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic                  pready,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pslverr,
    output logic                  req_vld,
    input  logic                  ack_vld,
    output logic                  wr_en,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] rd_data
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_write;
    logic                  r_pready;
    logic [DATA_WIDTH-1:0] r_prdata;
    logic                  r_req_vld;
    logic                  r_wr_en;
    logic                  r_rd_en;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic                  w_ack_take;
    logic                  w_cnt_hit;
    logic                  w_unused;

    // Setup is taken on psel alone, so penable carries no information here.
    assign w_unused = penable;

`ifdef REG_APB2NATIVE_TIMEOUT_EN
    logic [15:0] r_cnt;
    logic        r_pslverr;

    // r_cnt holds the number of ack-less cycles already spent, so a hit means
    // the current cycle is the last one counted before the transfer fails.
    assign w_cnt_hit = (r_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_pslverr <= 1'b0;
        end else begin
            if (r_state == S_IDLE)
                r_cnt <= '0;
            else if ((r_state == S_REQ || r_state == S_WAIT) && !ack_vld)
                r_cnt <= r_cnt + 16'd1;
            // An ack in the final counted cycle takes priority over the error.
            r_pslverr <= (r_state == S_REQ || r_state == S_WAIT) && !ack_vld && w_cnt_hit;
        end
    end

    assign pslverr = r_pslverr;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign w_cnt_hit = 1'b0;
    assign pslverr   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ack_take  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (psel)
                    w_state_nxt = S_REQ;
            end
            S_REQ, S_WAIT: begin
                if (ack_vld) begin
                    w_ack_take  = 1'b1;
                    w_state_nxt = S_RESP;
                end else if (w_cnt_hit) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state
    // they belong to while still coming from flops. S_REQ is only entered
    // from S_IDLE, so the live pwrite is the value being captured.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_write   <= 1'b0;
            r_pready  <= 1'b0;
            r_prdata  <= '0;
            r_req_vld <= 1'b0;
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_addr    <= '0;
            r_wr_data <= '0;
        end else begin
            if (r_state == S_IDLE && psel) begin
                r_write   <= pwrite;
                r_addr    <= paddr;
                r_wr_data <= pwdata;
            end
            r_req_vld <= (w_state_nxt == S_REQ);
            r_wr_en   <= (w_state_nxt == S_REQ) && pwrite;
            r_rd_en   <= (w_state_nxt == S_REQ) && !pwrite;
            r_pready  <= (w_state_nxt == S_RESP);
            // Zero except for the response cycle of a read that was acked.
            r_prdata  <= (w_ack_take && !r_write) ? rd_data : '0;
        end
    end

    assign pready  = r_pready;
    assign prdata  = r_prdata;
    assign req_vld = r_req_vld;
    assign wr_en   = r_wr_en;
    assign rd_en   = r_rd_en;
    assign addr    = r_addr;
    assign wr_data = r_wr_data;

endmodule

// File: tb/tb_reg_apb2native_if.sv
module tb_reg_apb2native_if;

    logic        clk;
    logic        rst_n;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [63:0] paddr;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic        req_vld;
    logic        ack_vld;
    logic        wr_en;
    logic        rd_en;
    logic [63:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;

    int n_vec;
    int n_err;

    reg_apb2native_if #(
        .ADDR_WIDTH    (64),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .psel   (psel),
        .penable(penable),
        .pwrite (pwrite),
        .paddr  (paddr),
        .pwdata (pwdata),
        .pready (pready),
        .prdata (prdata),
        .pslverr(pslverr),
        .req_vld(req_vld),
        .ack_vld(ack_vld),
        .wr_en  (wr_en),
        .rd_en  (rd_en),
        .addr   (addr),
        .wr_data(wr_data),
        .rd_data(rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".pready"},  pready,  1'b0);
        chk({tag, ".pslverr"}, pslverr, 1'b0);
        chk({tag, ".req_vld"}, req_vld, 1'b0);
        chk({tag, ".wr_en"},   wr_en,   1'b0);
        chk({tag, ".rd_en"},   rd_en,   1'b0);
        chk({tag, ".prdata"},  prdata,  32'h0);
    endtask

    task automatic setup(input logic wr, input logic [63:0] a, input logic [31:0] d);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = d;
    endtask

    task automatic apb_idle();
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    initial begin
        int seen_pready;
        int seen_err;
        n_vec   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        ack_vld = 1'b0;
        rd_data = '0;

        // ---- reset state
        step();
        step();
        chk_idle_outputs("rst");
        chk("rst.addr",    addr,    64'h0);
        chk("rst.wr_data", wr_data, 32'h0);
        rst_n = 1'b1;
        step();

        // ---- write, ack in the request cycle
        setup(1'b1, 64'h10, 32'hDEADBEEF);
        step();
        chk("wr.req_vld", req_vld, 1'b1);
        chk("wr.wr_en",   wr_en,   1'b1);
        chk("wr.rd_en",   rd_en,   1'b0);
        chk("wr.addr",    addr,    64'h10);
        chk("wr.wr_data", wr_data, 32'hDEADBEEF);
        chk("wr.pready0", pready,  1'b0);
        penable = 1'b1;
        ack_vld = 1'b1;
        step();
        chk("wr.pready",  pready,  1'b1);
        chk("wr.pslverr", pslverr, 1'b0);
        chk("wr.prdata",  prdata,  32'h0);
        chk("wr.req_off", req_vld, 1'b0);
        chk("wr.wr_off",  wr_en,   1'b0);
        ack_vld = 1'b0;
        apb_idle();
        step();
        chk("wr.pready_end", pready, 1'b0);

        // ---- read, ack three cycles after the request
        setup(1'b0, 64'h24, 32'h5555AAAA);
        step();
        chk("rd.req_vld", req_vld, 1'b1);
        chk("rd.rd_en",   rd_en,   1'b1);
        chk("rd.wr_en",   wr_en,   1'b0);
        chk("rd.addr",    addr,    64'h24);
        penable = 1'b1;
        paddr   = 64'hFF;
        step();
        chk("rd.req_off",   req_vld, 1'b0);
        chk("rd.rd_off",    rd_en,   1'b0);
        chk("rd.addr_hold", addr,    64'h24);
        step();
        chk("rd.wait2", pready, 1'b0);
        step();
        chk("rd.wait3", pready, 1'b0);
        ack_vld = 1'b1;
        rd_data = 32'h12345678;
        step();
        chk("rd.pready",  pready,  1'b1);
        chk("rd.prdata",  prdata,  32'h12345678);
        chk("rd.pslverr", pslverr, 1'b0);
        ack_vld = 1'b0;
        rd_data = 32'hFFFFFFFF;
        apb_idle();
        step();
        chk("rd.pready_end", pready, 1'b0);
        chk("rd.prdata_end", prdata, 32'h0);

        // ---- back-to-back: read 0x0 then write 0x4
        setup(1'b0, 64'h0, 32'h0);
        step();
        chk("b2b.r.req_vld", req_vld, 1'b1);
        chk("b2b.r.rd_en",   rd_en,   1'b1);
        chk("b2b.r.addr",    addr,    64'h0);
        penable = 1'b1;
        ack_vld = 1'b1;
        rd_data = 32'hCAFEF00D;
        step();
        chk("b2b.r.pready", pready, 1'b1);
        chk("b2b.r.prdata", prdata, 32'hCAFEF00D);
        ack_vld = 1'b0;
        apb_idle();
        step();
        chk("b2b.gap.pready",  pready,  1'b0);
        chk("b2b.gap.req_vld", req_vld, 1'b0);
        setup(1'b1, 64'h4, 32'hA5A5A5A5);
        step();
        chk("b2b.w.req_vld", req_vld, 1'b1);
        chk("b2b.w.wr_en",   wr_en,   1'b1);
        chk("b2b.w.rd_en",   rd_en,   1'b0);
        chk("b2b.w.addr",    addr,    64'h4);
        chk("b2b.w.wr_data", wr_data, 32'hA5A5A5A5);
        penable = 1'b1;
        ack_vld = 1'b1;
        step();
        chk("b2b.w.pready", pready, 1'b1);
        chk("b2b.w.prdata", prdata, 32'h0);
        chk("b2b.w.req_off", req_vld, 1'b0);
        ack_vld = 1'b0;
        apb_idle();
        step();
        chk("b2b.end.pready", pready, 1'b0);

        // ---- psel dropped mid-transfer still completes
        setup(1'b1, 64'h50, 32'h0000BEEF);
        step();
        chk("drop.req_vld", req_vld, 1'b1);
        apb_idle();
        step();
        chk("drop.wait", pready, 1'b0);
        ack_vld = 1'b1;
        step();
        chk("drop.pready", pready, 1'b1);
        ack_vld = 1'b0;
        step();
        chk("drop.end", pready, 1'b0);

        // ---- reset while waiting for ack
        setup(1'b1, 64'h30, 32'h11112222);
        step();
        chk("rst2.req_vld", req_vld, 1'b1);
        penable = 1'b1;
        step();
        chk("rst2.wait", req_vld, 1'b0);
        rst_n = 1'b0;
        apb_idle();
        step();
        chk_idle_outputs("rst2.after");
        chk("rst2.addr",    addr,    64'h0);
        chk("rst2.wr_data", wr_data, 32'h0);
        rst_n = 1'b1;
        step();
        ack_vld = 1'b1;
        step();
        chk("rst2.late_ack.pready",  pready,  1'b0);
        chk("rst2.late_ack.req_vld", req_vld, 1'b0);
        ack_vld = 1'b0;
        step();
        chk("rst2.late_ack2.pready", pready, 1'b0);
        setup(1'b0, 64'h8, 32'h0);
        step();
        chk("rst2.next.req_vld", req_vld, 1'b1);
        chk("rst2.next.addr",    addr,    64'h8);
        penable = 1'b1;
        ack_vld = 1'b1;
        rd_data = 32'h0BADCAFE;
        step();
        chk("rst2.next.pready", pready, 1'b1);
        chk("rst2.next.prdata", prdata, 32'h0BADCAFE);
        ack_vld = 1'b0;
        apb_idle();
        step();

`ifdef REG_APB2NATIVE_TIMEOUT_EN
        // ---- timeout: no ack, error response 8 cycles after req_vld
        setup(1'b0, 64'h40, 32'h0);
        rd_data = 32'h99999999;
        step();
        chk("to.req_vld", req_vld, 1'b1);
        penable = 1'b1;
        seen_pready = 0;
        for (int i = 1; i < 8; i++) begin
            step();
            if (pready) seen_pready++;
        end
        chk("to.no_early_pready", 64'(seen_pready), 64'd0);
        step();
        chk("to.pready",  pready,  1'b1);
        chk("to.pslverr", pslverr, 1'b1);
        chk("to.prdata",  prdata,  32'h0);
        apb_idle();
        ack_vld = 1'b1;
        step();
        chk("to.late.pready",  pready,  1'b0);
        chk("to.late.pslverr", pslverr, 1'b0);
        step();
        chk("to.late2.pready",  pready,  1'b0);
        chk("to.late2.req_vld", req_vld, 1'b0);
        ack_vld = 1'b0;
        step();

        // ---- ack in the last counted cycle wins
        setup(1'b0, 64'h44, 32'h0);
        step();
        chk("to2.req_vld", req_vld, 1'b1);
        penable = 1'b1;
        repeat (7) step();
        chk("to2.pready_pre", pready, 1'b0);
        ack_vld = 1'b1;
        rd_data = 32'h00000077;
        step();
        chk("to2.pready",  pready,  1'b1);
        chk("to2.pslverr", pslverr, 1'b0);
        chk("to2.prdata",  prdata,  32'h77);
        ack_vld = 1'b0;
        apb_idle();
        step();
        seen_err = 0;
`else
        // ---- no timeout: bridge waits indefinitely for ack
        setup(1'b0, 64'h40, 32'h0);
        rd_data = 32'h99999999;
        step();
        chk("nto.req_vld", req_vld, 1'b1);
        penable = 1'b1;
        seen_pready = 0;
        seen_err    = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (pready)  seen_pready++;
            if (pslverr) seen_err++;
        end
        chk("nto.no_pready",  64'(seen_pready), 64'd0);
        chk("nto.no_pslverr", 64'(seen_err),    64'd0);
        ack_vld = 1'b1;
        rd_data = 32'h0000600D;
        step();
        chk("nto.pready",  pready,  1'b1);
        chk("nto.pslverr", pslverr, 1'b0);
        chk("nto.prdata",  prdata,  32'h600D);
        ack_vld = 1'b0;
        apb_idle();
        step();
        chk("nto.end", pready, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reg_apb2native_if.md
Name: reg_apb2native_if

Overview:
- APB completer bridge: accepts APB3 transfers from an upstream APB requester and converts each into one native register-interface request (req_vld/ack_vld/wr_en/rd_en/addr/wr_data/rd_data).
- Sits in front of generated register blocks that expose the native interface, so they can hang off an APB fabric.
- Exactly one transfer is in flight at a time. All outputs are registered.

Parameters:
- ADDR_WIDTH, 64, width of paddr and addr
- DATA_WIDTH, 32, width of pwdata, prdata, wr_data and rd_data
- TIMEOUT_CYCLES, 255, cycles the bridge waits for ack_vld before failing the transfer; used only with REG_APB2NATIVE_TIMEOUT_EN; legal range 2 to 65535

Ports:
- clk  input  1  clock; single clock domain
- rst_n  input  1  reset, synchronous, active-low
- psel  input  1  APB select
- penable  input  1  APB enable (access phase)
- pwrite  input  1  APB direction; 1 = write
- paddr  input  ADDR_WIDTH  APB address
- pwdata  input  DATA_WIDTH  APB write data
- pready  output  1  transfer complete; one-cycle pulse
- prdata  output  DATA_WIDTH  read data; valid while pready=1
- pslverr  output  1  error response; valid while pready=1
- req_vld  output  1  native request strobe; one-cycle pulse
- ack_vld  input  1  native completion strobe
- wr_en  output  1  native write qualifier
- rd_en  output  1  native read qualifier
- addr  output  ADDR_WIDTH  native address
- wr_data  output  DATA_WIDTH  native write data
- rd_data  input  DATA_WIDTH  native read data; sampled while ack_vld=1

Behaviour:
- Reset: synchronous. At a posedge with rst_n=0:
  - state goes to S_IDLE;
  - pready, pslverr, req_vld, wr_en and rd_en go to 0;
  - prdata, addr and wr_data are cleared to 0.
- Reset mid-transfer abandons the transfer. No pready is issued, and a later ack_vld is ignored.
- State machine: S_IDLE, S_REQ, S_WAIT, S_RESP.
- S_IDLE:
  - When psel=1 (penable is don't-care), capture paddr, pwdata and pwrite, then go to S_REQ.
  - ack_vld is ignored in this state.
- S_REQ:
  - req_vld=1 for exactly this one cycle.
  - wr_en=pwrite and rd_en=!pwrite, as captured.
  - addr and wr_data hold the captured values.
  - If ack_vld=1 in this same cycle, go to S_RESP. Otherwise go to S_WAIT.
- S_WAIT:
  - req_vld, wr_en and rd_en are 0.
  - addr and wr_data hold their values until the next capture.
  - On ack_vld=1, go to S_RESP.
- Read data: on the ack cycle, rd_data is registered into prdata for reads. For writes, prdata is 0.
- S_RESP:
  - pready=1 for exactly one cycle, with pslverr=0 (except on timeout) and prdata valid.
  - Next state is S_IDLE. prdata returns to 0 after the pulse.
- Latency:
  - Setup sampled at edge T.
  - req_vld is high in cycle T+1.
  - pready is high in the cycle after the ack cycle; with a same-cycle ack, that is T+2.
- APB inputs changing after capture are ignored until the next S_IDLE.
- Back-to-back transfers: a new setup in the cycle after the pready pulse is accepted in S_IDLE with no lost transfer. Throughput is at most one transfer per 3 cycles.
- psel dropping during S_REQ/S_WAIT (protocol violation): the native transfer still completes and pready still pulses.
- wr_en and rd_en are never both 1, and are never 1 without req_vld.

Optional Feature:
- Macro: REG_APB2NATIVE_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to S_REQ and counts every S_REQ/S_WAIT cycle that has no ack.
  - If ack_vld is still absent when the count reaches TIMEOUT_CYCLES, the FSM goes to S_RESP with pslverr=1 and prdata=0.
  - ack_vld in the final counted cycle wins: normal response, pslverr=0.
  - A late ack arriving in S_RESP or S_IDLE is ignored.
- Undefined:
  - No counter logic exists; the bridge waits indefinitely for ack_vld.
  - pslverr is a constant 0.

Test Plan:
- Write, same-cycle ack:
  - Stimulus: setup with paddr=0x10, pwdata=0xDEADBEEF, pwrite=1; ack_vld=1 in the req cycle.
  - Response: a single req_vld with wr_en=1, rd_en=0, addr=0x10, wr_data=0xDEADBEEF; pready one cycle later with pslverr=0.
- Read, delayed ack:
  - Stimulus: setup with paddr=0x24, pwrite=0; ack_vld arrives 3 cycles after req_vld with rd_data=0x12345678.
  - Response: pready in the cycle after the ack, prdata=0x12345678; prdata=0 in the next cycle.
- Back-to-back:
  - Stimulus: read of 0x0 then write of 0x4/0xA5A5A5A5, with the second setup immediately after the first pready.
  - Response: exactly two req_vld pulses, in order, with correct qualifiers; two pready pulses.
- Reset mid-transfer:
  - Stimulus: rst_n=0 for one cycle while in S_WAIT; ack_vld=1 two cycles later.
  - Response: all outputs are 0 after the reset edge; no pready; the next transfer completes normally.
- Timeout, macro defined:
  - Stimulus: TIMEOUT_CYCLES=8, no ack.
  - Response: pready=1 with pslverr=1 and prdata=0 exactly 8 cycles after the req_vld cycle; a late ack_vld is ignored.
  - Second run: ack in the 8th counted cycle gives pslverr=0.
- Macro undefined:
  - Stimulus: same no-ack stimulus as the timeout test.
  - Response: no pready for 1000 cycles, pslverr stays 0; a later ack_vld completes the transfer normally.
